qa_output_fifo: RTL and testbench

//  Elastic buffer downstream of the QA wrapper's merged sample/message stream.

---
 rtl/qa_output_fifo.sv | 111 +++++++++++
 tb/tb_qa_output_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/qa_output_fifo.sv
// qa_output_fifo
// Elastic buffer for the QA wrapper's merged sample/message stream.
// DEPTH-1 words of RAM sit behind a show-ahead output register, so the
// total capacity is DEPTH words. Upstream cannot be throttled: a word that
// arrives while full (and nothing leaves) is dropped, and the sticky error
// flag records the loss. Word order is never changed.
module qa_output_fifo #(
    parameter int WDTH         = 32,
    parameter int DEPTH        = 64,
    parameter int LOG_DEPTH    = 6,
    parameter int AFULL_THRESH = 56
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WDTH-1:0]      in_data,
    input  logic                 in_nd,
    output logic [WDTH-1:0]      out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LOG_DEPTH:0]   count,
    output logic                 almost_full,
    output logic                 error
);

    localparam int SLOTS = DEPTH - 1;
    localparam logic [LOG_DEPTH:0]   FULL_CNT  = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0]   AFULL_CNT = (LOG_DEPTH+1)'(AFULL_THRESH);
    localparam logic [LOG_DEPTH:0]   ONE_CNT   = (LOG_DEPTH+1)'(1);
    localparam logic [LOG_DEPTH-1:0] LAST_SLOT = LOG_DEPTH'(DEPTH - 2);
    localparam logic [LOG_DEPTH-1:0] ONE_PTR   = LOG_DEPTH'(1);

    logic [WDTH-1:0]      mem [0:SLOTS-1];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;

    logic               push;
    logic               pop;
    logic               full;
    logic               accept;
    logic               ram_has_data;
    logic               ram_wr;
    logic               ram_rd;
    logic               load_out;
    logic [LOG_DEPTH:0] count_nxt;

    // Storage pointers wrap over DEPTH-1 slots, not a power of two.
    function automatic logic [LOG_DEPTH-1:0] ptr_inc(input logic [LOG_DEPTH-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + ONE_PTR;
    endfunction

    // Steer each word: straight into the output stage when it would
    // otherwise be empty after this edge, else into the RAM.
    always_comb begin
        push         = in_nd;
        pop          = out_valid & out_ready;
        full         = (count == FULL_CNT);
        accept       = push & (~full | pop);
        // The output register holds one word, so RAM holds count-1 when valid.
        ram_has_data = (count > ONE_CNT);
        ram_rd       = pop & ram_has_data;
        load_out     = accept & (~out_valid | (pop & ~ram_has_data));
        ram_wr       = accept & ~load_out;
        count_nxt    = count;
        if (accept && !pop)
            count_nxt = count + ONE_CNT;
        else if (pop && !accept)
            count_nxt = count - ONE_CNT;
    end

    // RAM write port; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && ram_wr)
            mem[wr_ptr] <= in_data;
    end

    // Pointers, show-ahead output register, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            count       <= '0;
            almost_full <= 1'b0;
            error       <= 1'b0;
        end else begin
            if (ram_wr)
                wr_ptr <= ptr_inc(wr_ptr);
            if (ram_rd)
                rd_ptr <= ptr_inc(rd_ptr);

            // Refill on the same edge as the pop so bursts drain at 1 word/cycle.
            // On a full push+pop the read sees the slot's old word.
            if (ram_rd) begin
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
            end else if (load_out) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end

            count       <= count_nxt;
            almost_full <= (count_nxt >= AFULL_CNT);
            if (push && full && !pop)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qa_output_fifo.sv
// tb_qa_output_fifo
// Directed vectors against qa_output_fifo at DEPTH=64, plus a long random
// run checked against a queue-based reference.
module tb_qa_output_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_nd;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  count;
    logic        almost_full;
    logic        error;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q[$];
    logic        m_err;

    qa_output_fifo #(
        .WDTH(32), .DEPTH(64), .LOG_DEPTH(6), .AFULL_THRESH(56)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_nd(in_nd),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .almost_full(almost_full), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; sampling happens 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_nd     = 1'b0;
        out_ready = 1'b0;

        // ---- 1: reset state, then 5 pushes streaming straight through
        step();
        step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("t1_idle_valid", 32'(out_valid), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            in_nd   = 1'b1;
            in_data = 32'(i);
            step();
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_data", out_data, 32'(i));
            chk("t1_count", 32'(count), 32'd1);
        end
        in_nd = 1'b0;
        step();
        chk("t1_empty_valid", 32'(out_valid), 32'd0);
        chk("t1_empty_count", 32'(count), 32'd0);
        chk("t1_error", 32'(error), 32'd0);

        // ---- 2: fill to 64, overflow, drain
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in_nd   = 1'b1;
            in_data = 32'hA000_0000 + 32'(i);
            step();
            chk("t2_count", 32'(count), 32'(i + 1));
            chk("t2_afull", 32'(almost_full), (i + 1 >= 56) ? 32'd1 : 32'd0);
        end
        chk("t2_error_pre", 32'(error), 32'd0);
        in_data = 32'hA000_0040;
        step();
        chk("t2_ovf_error", 32'(error), 32'd1);
        chk("t2_ovf_count", 32'(count), 32'd64);
        in_nd     = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 64; j++) begin
            chk("t2_drain_valid", 32'(out_valid), 32'd1);
            chk("t2_drain_data", out_data, 32'hA000_0000 + 32'(j));
            step();
        end
        chk("t2_end_valid", 32'(out_valid), 32'd0);
        chk("t2_end_count", 32'(count), 32'd0);
        chk("t2_end_afull", 32'(almost_full), 32'd0);
        chk("t2_sticky_error", 32'(error), 32'd1);

        // ---- 3: push and pop on the same edge while full
        do_reset();
        chk("t3_rst_error", 32'(error), 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in_nd   = 1'b1;
            in_data = 32'hB000_0000 + 32'(i);
            step();
        end
        chk("t3_full_count", 32'(count), 32'd64);
        in_data   = 32'hC000_0000;
        out_ready = 1'b1;
        step();
        in_nd = 1'b0;
        chk("t3_pp_count", 32'(count), 32'd64);
        chk("t3_pp_error", 32'(error), 32'd0);
        for (int j = 1; j < 64; j++) begin
            chk("t3_drain_data", out_data, 32'hB000_0000 + 32'(j));
            step();
        end
        chk("t3_last_valid", 32'(out_valid), 32'd1);
        chk("t3_last_data", out_data, 32'hC000_0000);
        step();
        chk("t3_end_count", 32'(count), 32'd0);

        // ---- 5: reset mid-burst drops everything
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_nd   = 1'b1;
            in_data = 32'hD000_0000 + 32'(i);
            step();
        end
        chk("t5_pre_count", 32'(count), 32'd20);
        rst_n   = 1'b0;
        in_data = 32'hDEAD_BEEF;
        step();
        rst_n = 1'b1;
        in_nd = 1'b0;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_error", 32'(error), 32'd0);
        chk("t5_data", out_data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            in_nd   = 1'b1;
            in_data = 32'hE000_0000 + 32'(i);
            step();
        end
        in_nd     = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("t5_new_data", out_data, 32'hE000_0000 + 32'(j));
            step();
        end
        chk("t5_end_valid", 32'(out_valid), 32'd0);

        // ---- 6: hold stable under backpressure, then pop once per cycle
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_nd   = 1'b1;
            in_data = 32'hF000_0000 + 32'(i);
            step();
        end
        in_nd = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t6_hold_data", out_data, 32'hF000_0000);
            chk("t6_hold_count", 32'(count), 32'd3);
        end
        out_ready = 1'b1;
        step();
        chk("t6_pop1_data", out_data, 32'hF000_0001);
        chk("t6_pop1_count", 32'(count), 32'd2);
        step();
        chk("t6_pop2_data", out_data, 32'hF000_0002);
        chk("t6_pop2_count", 32'(count), 32'd1);
        step();
        chk("t6_pop3_valid", 32'(out_valid), 32'd0);
        chk("t6_pop3_count", 32'(count), 32'd0);

        // ---- 4: random traffic against a queue reference
        do_reset();
        q.delete();
        m_err = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            logic nd, rdy, mpop, mfull;
            logic [31:0] d;
            chk("rnd_count", 32'(count), 32'(q.size()));
            chk("rnd_valid", 32'(out_valid), (q.size() > 0) ? 32'd1 : 32'd0);
            chk("rnd_error", 32'(error), 32'(m_err));
            if (q.size() > 0)
                chk("rnd_data", out_data, q[0]);
            nd  = ($urandom_range(99) < 50);
            rdy = ($urandom_range(99) < 30);
            d   = $urandom;
            in_nd     = nd;
            in_data   = d;
            out_ready = rdy;
            mpop  = (q.size() > 0) && rdy;
            mfull = (q.size() == 64);
            if (nd && mfull && !mpop)
                m_err = 1'b1;
            if (mpop)
                void'(q.pop_front());
            if (nd && (!mfull || mpop))
                q.push_back(d);
            step();
        end
        in_nd = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
